// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// No logic; widths here set the header count and word-index sizes.
package imem_pkg;
  localparam int          IMEM_ADDR_W = 8;
  localparam int          HDR_BYTES   = 2;
  localparam int          CNT_W       = HDR_BYTES * 8;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of the byte stream, CPU fetch and memory port signals of the loader.
// slave is the controller view, master the CPU/memory/stream side.
interface imem_load_ctrl_if #(
  parameter int ADDR_W = imem_pkg::IMEM_ADDR_W
);
  logic              load_req;
  logic              load_abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [31:0]       cpu_pc;
  logic [31:0]       cpu_instr;
  logic              cpu_hold;
  logic              cpu_restart;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              load_done;
  logic              load_err;

  modport slave (
    input  load_req, load_abort, byte_valid, byte_data, cpu_pc, mem_rdata,
    output byte_ready, cpu_instr, cpu_hold, cpu_restart, mem_raddr,
           mem_we, mem_waddr, mem_wdata, load_done, load_err
  );

  modport master (
    output load_req, load_abort, byte_valid, byte_data, cpu_pc, mem_rdata,
    input  byte_ready, cpu_instr, cpu_hold, cpu_restart, mem_raddr,
           mem_we, mem_waddr, mem_wdata, load_done, load_err
  );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; word_vld_o is combinational
// on the 4th shifted byte, and word_o carries that byte in its low lane.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_vld_o
);
  logic [23:0] sh_q;
  logic [1:0]  bcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q   <= '0;
      bcnt_q <= '0;
    end else if (clr_i) begin
      sh_q   <= '0;
      bcnt_q <= '0;
    end else if (shift_i) begin
      sh_q   <= {sh_q[15:0], byte_i};
      bcnt_q <= bcnt_q + 2'd1;
    end
  end

  // Only three earlier bytes need storing; the 4th is taken straight from the input.
  assign word_o     = {sh_q, byte_i};
  assign word_vld_o = shift_i && (bcnt_q == 2'd3);
endmodule

// File: rtl/imem_load_ctrl.sv
// Holds the CPU, loads a length-prefixed byte image into instruction memory, then restarts it.
// Fetch path is zero-latency; each word is written one cycle after its 4th byte.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int START_WORD = 0,
  parameter int MAX_WORDS  = 256
) (
  input  logic             clk,
  input  logic             reset,
  imem_load_ctrl_if.slave  bus
);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, idx_q, hdr_w, idx_inc;
  logic                byte_ready_q, cpu_hold_q, done_q, err_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_waddr_q;
  logic [31:0]         mem_wdata_q, word;
  logic                xfer, shift, word_vld, load_start, abort_ok, pc_unused;

  assign xfer       = bus.byte_valid && byte_ready_q;
  assign load_start = (state_q == ST_RUN) && bus.load_req;
  assign abort_ok   = bus.load_abort && (state_q inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_WRITE});
  assign shift      = (state_q == ST_DATA) && xfer && !bus.load_abort;
  assign hdr_w      = {cnt_q[CNT_W-1:8], bus.byte_data};
  assign idx_inc    = idx_q + CNT_W'(1);

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (load_start),
    .shift_i    (shift),
    .byte_i     (bus.byte_data),
    .word_o     (word),
    .word_vld_o (word_vld)
  );

  always_comb begin
    state_d = state_q;
    if (abort_ok) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_RUN:    if (bus.load_req) state_d = ST_HDR_HI;
        ST_HDR_HI: if (xfer) state_d = ST_HDR_LO;
        ST_HDR_LO: if (xfer) state_d = (hdr_w == '0) ? ST_DONE : ST_DATA;
        ST_DATA:   if (word_vld) state_d = ST_WRITE;
        ST_WRITE:  state_d = (idx_inc == cnt_q) ? ST_DONE : ST_DATA;
        ST_DONE:   state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      idx_q        <= '0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= state_d inside {ST_HDR_HI, ST_HDR_LO, ST_DATA};
      cpu_hold_q   <= (state_d != ST_RUN);
      done_q       <= (state_d == ST_DONE);
      mem_we_q     <= (state_d == ST_WRITE) && (32'(idx_q) < MAX_WORDS);

      if (state_q == ST_DATA && state_d == ST_WRITE) begin
        mem_waddr_q <= ADDR_W'(START_WORD) + idx_q[ADDR_W-1:0];
        mem_wdata_q <= word;
      end

      if (load_start) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end
      if (state_q == ST_HDR_HI && xfer && !abort_ok) begin
        cnt_q[CNT_W-1:8] <= bus.byte_data;
      end
      if (state_q == ST_HDR_LO && xfer && !abort_ok) begin
        cnt_q[7:0] <= bus.byte_data;
        idx_q      <= '0;
        if (32'(hdr_w) > MAX_WORDS) err_q <= 1'b1;
      end
      if (state_q == ST_WRITE) begin
        idx_q <= idx_inc;
      end
      if (abort_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign pc_unused       = ^{bus.cpu_pc[31:ADDR_W+2], bus.cpu_pc[1:0]};
  assign bus.mem_raddr   = bus.cpu_pc[ADDR_W+1:2];
  assign bus.cpu_instr   = (state_q == ST_RUN) ? bus.mem_rdata : NOP_INSTR;
  assign bus.byte_ready  = byte_ready_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.cpu_restart = done_q;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_waddr   = mem_waddr_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule
